// File: rtl/rx_frame_receiver_if.sv
// Receive-side word bus: the receiver presents a word plus status flags,
// the consumer acknowledges with rx_ready.
interface rx_frame_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/rx_frame_receiver.sv
// Oversampled asynchronous serial frame receiver with mid-bit sampling,
// optional parity, 1/2 stop bits and a single-word holding register.
module rx_frame_receiver #(
  parameter int OVERSAMPLE = 4,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 sample_tick,
  input  logic                 rxd,
  rx_frame_receiver_if.master  rx_bus,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_ON    = (PARITY_EN != 0);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic                 rxd_p0;
  logic                 rxd_p1;
  logic [2:0]           state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_p1;
  logic                 perr_p1;
  logic                 vld_p1;
  logic                 mid_bit;

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] word,
                                           input logic                 par_bit);
    return par_bit ^ (^word) ^ PAR_ODD;
  endfunction

  assign mid_bit = sample_tick && (tick_cnt == TICK_LAST);
  assign busy    = (state != S_IDLE);

  // Stage p0/p1: line synchroniser and frame FSM; vld_p1 marks a completed frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_p0           <= 1'b1;
      rxd_p1           <= 1'b1;
      state            <= S_IDLE;
      tick_cnt         <= '0;
      bit_cnt          <= '0;
      vld_p1           <= 1'b0;
      rx_bus.frame_err <= 1'b0;
    end else begin
      rxd_p0           <= rxd;
      rxd_p1           <= rxd_p0;
      vld_p1           <= 1'b0;
      rx_bus.frame_err <= 1'b0;
      if (!rx_en && state != S_IDLE) begin
        state    <= S_IDLE;
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (sample_tick) begin
        case (state)
          S_IDLE: begin
            if (rx_en && !rxd_p1) begin
              state    <= S_START;
              tick_cnt <= '0;
            end
          end
          S_START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rxd_p1 ? S_IDLE : S_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (tick_cnt != TICK_LAST) begin
              tick_cnt <= tick_cnt + 1'b1;
            end else begin
              tick_cnt <= '0;
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                state   <= PAR_ON ? S_PARITY : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          S_PARITY: begin
            if (tick_cnt != TICK_LAST) begin
              tick_cnt <= tick_cnt + 1'b1;
            end else begin
              tick_cnt <= '0;
              state    <= S_STOP;
            end
          end
          S_STOP: begin
            if (tick_cnt != TICK_LAST) begin
              tick_cnt <= tick_cnt + 1'b1;
            end else begin
              tick_cnt <= '0;
              if (!rxd_p1) begin
                rx_bus.frame_err <= 1'b1;
                state            <= S_BREAK;
              end else if (bit_cnt == STOP_LAST) begin
                vld_p1 <= 1'b1;
                state  <= S_IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          S_BREAK: begin
            if (rxd_p1) state <= S_IDLE;
          end
          default: begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        endcase
      end
    end
  end

  // Stage p1: data shift register and parity result, no reset needed
  always_ff @(posedge clk) begin
    if (mid_bit && state == S_DATA)
      shift_p1 <= {rxd_p1, shift_p1[DATA_BITS-1:1]};
    if (mid_bit && state == S_PARITY)
      perr_p1 <= parity_mismatch(shift_p1, rxd_p1);
  end

  // Stage p2: holding register; a new word always wins over the old one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_bus.rx_data     <= '0;
      rx_bus.rx_valid    <= 1'b0;
      rx_bus.parity_err  <= 1'b0;
      rx_bus.overrun_err <= 1'b0;
    end else begin
      rx_bus.overrun_err <= 1'b0;
      if (vld_p1) begin
        rx_bus.rx_data     <= shift_p1;
        rx_bus.parity_err  <= PAR_ON & perr_p1;
        rx_bus.rx_valid    <= 1'b1;
        rx_bus.overrun_err <= rx_bus.rx_valid & ~rx_bus.rx_ready;
      end else if (rx_bus.rx_valid && rx_bus.rx_ready) begin
        rx_bus.rx_valid <= 1'b0;
      end
    end
  end

endmodule
